// File: rtl/obstacle_gen_pkg.sv
// Shared types and constants for the obstacle column generator.
// OBST_CEILING_EN turns shape 3 into a ceiling bar; otherwise it aliases shape 2.
package obstacle_pkg;

  localparam int GAP_W = 6;
  localparam int LVL_W = 4;
  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GAP  = 2'd1,
    EMIT = 2'd2
  } state_e;

  localparam logic [15:0] LFSR_TAPS  = 16'hB400;
  localparam logic [15:0] SHAPE_LOW  = 16'h0003;
  localparam logic [15:0] SHAPE_TALL = 16'h000F;
  localparam logic [15:0] SHAPE_CEIL = 16'hC000;
  localparam logic [1:0]  WIDTH_SHORT = 2'd2;
  localparam logic [1:0]  WIDTH_LONG  = 2'd3;

  function automatic logic [15:0] shape_col(input logic [1:0] sel);
    logic [15:0] col;
    case (sel)
      2'd0:    col = SHAPE_LOW;
      2'd1:    col = SHAPE_LOW;
      2'd2:    col = SHAPE_TALL;
`ifdef OBST_CEILING_EN
      2'd3:    col = SHAPE_CEIL;
`else
      2'd3:    col = SHAPE_TALL;
`endif
      default: col = 16'h0000;
    endcase
    return col;
  endfunction

  function automatic logic [1:0] shape_width(input logic [1:0] sel);
    return (sel == 2'd1) ? WIDTH_LONG : WIDTH_SHORT;
  endfunction

endpackage

// File: rtl/obstacle_gen_if.sv
// Control and column-output bundle between the tick source and the obstacle generator.
interface obstacle_gen_if #(parameter int COL_W = 16);

  logic                         tick;
  logic                         run;
  logic                         clear;
  logic [COL_W-1:0]             col_out;
  logic                         col_valid;
  logic [obstacle_pkg::GAP_W-1:0] gap_len;
  logic [obstacle_pkg::LVL_W-1:0] level;
  logic [obstacle_pkg::CNT_W-1:0] obst_cnt;

  modport master (
    output tick, run, clear,
    input  col_out, col_valid, gap_len, level, obst_cnt
  );

  modport slave (
    input  tick, run, clear,
    output col_out, col_valid, gap_len, level, obst_cnt
  );

endinterface

// File: rtl/obstacle_gen_lfsr16.sv
// Free-running 16-bit right-shift Galois LFSR; a zero seed is replaced by 1 so it never locks up.
module lfsr16
  import obstacle_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] seed_i,
  output logic [15:0] q_o
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  // next-state: shift right, fold the taps in when a one falls out
  always_comb begin
    lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= (seed_i == 16'h0000) ? 16'h0001 : seed_i;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign q_o = lfsr_q;

endmodule

// File: rtl/obstacle_gen.sv
// Produces one playfield column per accepted scroll tick: gaps, LFSR-chosen shapes, difficulty ramp.
// Optional build macro: OBST_CEILING_EN (ceiling-bar shape for sel 3).
module obstacle_gen
  import obstacle_pkg::*;
#(
  parameter int          COL_W    = 16,
  parameter int          GAP_INIT = 50,
  parameter int          GAP_MIN  = 15,
  parameter int          GAP_STEP = 2,
  parameter logic [15:0] SEED     = 16'hACE1
) (
  input  logic           clk,
  input  logic           rst_n,
  obstacle_gen_if.slave  bus
);

  localparam logic [GAP_W-1:0] GAP_INIT_C = GAP_W'(GAP_INIT);
  localparam logic [GAP_W-1:0] GAP_MIN_C  = GAP_W'(GAP_MIN);
  localparam logic [GAP_W-1:0] GAP_STEP_C = GAP_W'(GAP_STEP);
  localparam logic [GAP_W:0]   RAMP_LIMIT = (GAP_W+1)'(GAP_MIN + GAP_STEP);

  state_e           state_q,     state_d;
  logic [GAP_W-1:0] gap_cnt_q,   gap_cnt_d;
  logic [GAP_W-1:0] gap_len_q,   gap_len_d;
  logic [1:0]       w_cnt_q,     w_cnt_d;
  logic [1:0]       sel_q,       sel_d;
  logic [LVL_W-1:0] level_q,     level_d;
  logic [CNT_W-1:0] obst_cnt_q,  obst_cnt_d;
  logic [COL_W-1:0] col_out_q,   col_out_d;
  logic             col_valid_q, col_valid_d;
  logic [15:0]      lfsr_s;
  logic             accept;

  lfsr16 u_lfsr (
    .clk    (clk),
    .rst_n  (rst_n),
    .seed_i (SEED),
    .q_o    (lfsr_s)
  );

  assign accept = bus.tick & bus.run & ~bus.clear;

  // next-state, column and difficulty logic
  always_comb begin
    state_d     = state_q;
    gap_cnt_d   = gap_cnt_q;
    gap_len_d   = gap_len_q;
    w_cnt_d     = w_cnt_q;
    sel_d       = sel_q;
    level_d     = level_q;
    obst_cnt_d  = obst_cnt_q;
    col_out_d   = col_out_q;
    col_valid_d = 1'b0;
    if (bus.clear) begin
      state_d    = IDLE;
      gap_cnt_d  = '0;
      gap_len_d  = GAP_INIT_C;
      w_cnt_d    = 2'd0;
      sel_d      = 2'd0;
      level_d    = '0;
      obst_cnt_d = '0;
      col_out_d  = '0;
    end else if (accept) begin
      col_valid_d = 1'b1;
      case (state_q)
        IDLE: begin
          col_out_d = '0;
          gap_cnt_d = gap_len_q - 6'd1;
          state_d   = GAP;
        end
        GAP: begin
          col_out_d = '0;
          if (gap_cnt_q == 6'd1) begin
            sel_d   = lfsr_s[1:0];
            w_cnt_d = shape_width(lfsr_s[1:0]);
            state_d = EMIT;
          end else begin
            gap_cnt_d = gap_cnt_q - 6'd1;
          end
        end
        EMIT: begin
          col_out_d = COL_W'(shape_col(sel_q));
          w_cnt_d   = w_cnt_q - 2'd1;
          if (w_cnt_q == 2'd1) begin
            obst_cnt_d = (obst_cnt_q == 8'hFF) ? obst_cnt_q : obst_cnt_q + 8'd1;
            // compare against MIN+STEP in 7 bits instead of subtracting first
            if ({1'b0, gap_len_q} >= RAMP_LIMIT) begin
              gap_len_d = gap_len_q - GAP_STEP_C;
            end else begin
              gap_len_d = GAP_MIN_C;
              level_d   = (level_q == 4'hF) ? level_q : level_q + 4'd1;
            end
            gap_cnt_d = gap_len_d;
            state_d   = GAP;
          end else begin
            state_d = EMIT;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end else begin
      col_valid_d = 1'b0;
    end
  end

  // state and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      gap_cnt_q   <= '0;
      gap_len_q   <= GAP_INIT_C;
      w_cnt_q     <= 2'd0;
      sel_q       <= 2'd0;
      level_q     <= '0;
      obst_cnt_q  <= '0;
      col_out_q   <= '0;
      col_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      gap_cnt_q   <= gap_cnt_d;
      gap_len_q   <= gap_len_d;
      w_cnt_q     <= w_cnt_d;
      sel_q       <= sel_d;
      level_q     <= level_d;
      obst_cnt_q  <= obst_cnt_d;
      col_out_q   <= col_out_d;
      col_valid_q <= col_valid_d;
    end
  end

  assign bus.col_out   = col_out_q;
  assign bus.col_valid = col_valid_q;
  assign bus.gap_len   = gap_len_q;
  assign bus.level     = level_q;
  assign bus.obst_cnt  = obst_cnt_q;

endmodule

// File: tb/tb_obstacle_gen.sv
// Directed bench for obstacle_gen: reset, gaps, shapes, ramp, pause, clear/tick collision.
module tb_obstacle_gen;
  import obstacle_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  obstacle_gen_if #(.COL_W(16)) bus ();

  obstacle_gen dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // reference LFSR: 16'hACE1 seed, right-shift Galois, taps 16'hB400
  logic [15:0] m_lfsr;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_lfsr <= 16'hACE1;
    else        m_lfsr <= {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
  end

  int          m_zeros;
  int          m_shape;
  int          m_k;
  logic [15:0] m_pat;
  logic [15:0] m_last;
  logic        paused;

  function automatic logic [15:0] exp_pat(input logic [1:0] s);
    case (s)
      2'd0, 2'd1: return 16'h0003;
      2'd2:       return 16'h000F;
`ifdef OBST_CEILING_EN
      default:    return 16'hC000;
`else
      default:    return 16'h000F;
`endif
    endcase
  endfunction

  function automatic int exp_w(input logic [1:0] s);
    return (s == 2'd1) ? 3 : 2;
  endfunction

  function automatic int exp_gap(input int k);
    return (k <= 17) ? 50 - 2 * k : 15;
  endfunction

  function automatic int exp_level(input int k);
    if (k <= 17) return 0;
    return (k - 17 > 15) ? 15 : k - 17;
  endfunction

  task automatic model_reset();
    m_zeros = 50;
    m_shape = 0;
    m_k     = 0;
    m_last  = 16'h0000;
  endtask

  task automatic check_counters(input string tag);
    check_eq({tag, "_gap_len"},  bus.gap_len,  32'(exp_gap(m_k)));
    check_eq({tag, "_level"},    bus.level,    32'(exp_level(m_k)));
    check_eq({tag, "_obst_cnt"}, bus.obst_cnt, 32'(m_k));
  endtask

  // one accepted tick (left high so consecutive calls are back-to-back)
  task automatic do_tick();
    logic [15:0] e;
    logic        done;
    done     = 1'b0;
    bus.tick = 1'b1;
    if (m_zeros > 0) begin
      e = 16'h0000;
      if (m_zeros == 1) begin
        m_pat   = exp_pat(m_lfsr[1:0]);
        m_shape = exp_w(m_lfsr[1:0]);
      end
      m_zeros--;
    end else begin
      e = m_pat;
      m_shape--;
      if (m_shape == 0) begin
        done    = 1'b1;
        m_k++;
        m_zeros = exp_gap(m_k);
      end
    end
    @(negedge clk);
    check_eq("col_valid", bus.col_valid, 32'd1);
    check_eq("col_out", bus.col_out, 32'(e));
    m_last = e;
    if (done) check_counters("ramp");
  endtask

  task automatic idle_cycle();
    bus.tick = 1'b0;
    @(negedge clk);
    check_eq("idle_valid", bus.col_valid, 32'd0);
    check_eq("idle_hold", bus.col_out, 32'(m_last));
  endtask

  logic [1:0] want_sel [4];

  initial begin
    want_sel[0] = 2'd0;
    want_sel[1] = 2'd1;
    want_sel[2] = 2'd2;
    want_sel[3] = 2'd3;
    paused    = 1'b0;
    rst_n     = 1'b0;
    bus.tick  = 1'b0;
    bus.run   = 1'b0;
    bus.clear = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_eq("rst_col_out", bus.col_out, 32'd0);
    check_eq("rst_col_valid", bus.col_valid, 32'd0);
    check_counters("rst");
    rst_n   = 1'b1;
    bus.run = 1'b1;

    // first shape after 50 zero columns, then async reset mid-shape
    for (int i = 0; i < 51; i++) do_tick();
    check_eq("first_shape_nonzero", (m_last != 16'h0000), 32'd1);
    bus.tick = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_eq("async_col_out", bus.col_out, 32'd0);
    check_eq("async_col_valid", bus.col_valid, 32'd0);
    check_eq("async_gap_len", bus.gap_len, 32'd50);
    check_eq("async_level", bus.level, 32'd0);
    check_eq("async_obst_cnt", bus.obst_cnt, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    // ramp run; first four shapes steered to sel 0..3, pause inside the fifth
    while (m_k < 34) begin
      if (m_k < 4 && m_zeros == 1) begin
        for (int g = 0; g < 64 && m_lfsr[1:0] != want_sel[m_k]; g++) idle_cycle();
        check_eq("sel_align", m_lfsr[1:0], want_sel[m_k]);
      end
      if (m_k == 4 && m_shape == 1 && !paused) begin
        paused  = 1'b1;
        bus.run = 1'b0;
        for (int p = 0; p < 10; p++) begin
          bus.tick = 1'b1;
          @(negedge clk);
          check_eq("pause_valid", bus.col_valid, 32'd0);
          bus.tick = 1'b0;
          @(negedge clk);
        end
        check_eq("pause_col_out", bus.col_out, 32'(m_last));
        check_counters("pause");
        bus.run = 1'b1;
      end
      do_tick();
    end

    // clear and tick together mid-gap
    for (int i = 0; i < 3; i++) do_tick();
    bus.clear = 1'b1;
    bus.tick  = 1'b1;
    @(negedge clk);
    bus.clear = 1'b0;
    bus.tick  = 1'b0;
    model_reset();
    check_eq("clr_col_valid", bus.col_valid, 32'd0);
    check_eq("clr_col_out", bus.col_out, 32'd0);
    check_counters("clr");
    for (int i = 0; i < 51; i++) do_tick();
    check_eq("clr_first_shape_nonzero", (m_last != 16'h0000), 32'd1);
    bus.tick = 1'b0;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
